// File: rtl/bf_pkg.sv
// Shared types for the Brainfuck execution core.
//   bf_cmd_t        : 3-bit command encodings as they arrive on prog_cmd
//   bf_exec_state_t : execution controller states
//   bf_err_t        : err_code values reported when execution aborts
package bf_pkg;

    typedef enum logic [2:0] {
        CMD_INC        = 3'b000,  // '+'
        CMD_DEC        = 3'b001,  // '-'
        CMD_LOOP_OPEN  = 3'b010,  // '['
        CMD_LOOP_CLOSE = 3'b011,  // ']'
        CMD_PTR_INC    = 3'b100,  // '>'
        CMD_PTR_DEC    = 3'b101,  // '<'
        CMD_OUT        = 3'b110,  // '.'
        CMD_IN         = 3'b111   // ','
    } bf_cmd_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_OUT_WAIT,
        ST_IN_WAIT,
        ST_SKIP_FETCH,
        ST_SKIP,
        ST_DONE,
        ST_ERROR
    } bf_exec_state_t;

    typedef enum logic [1:0] {
        ERR_NONE            = 2'b00,
        ERR_OVF             = 2'b01,
        ERR_UNMATCHED_CLOSE = 2'b10,
        ERR_UNMATCHED_OPEN  = 2'b11
    } bf_err_t;

    // A program is running in every state except the three resting ones.
    function automatic logic state_is_active(bf_exec_state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
    endfunction

endpackage

// File: rtl/bf_loop_stack.sv
// Loop-address stack holding the command address of each open '['.
// Ports:
//   clk, reset_trigger : clock, asynchronous active-high reset (empties stack)
//   i_push/i_push_data : push an address (dropped when full)
//   i_pop              : discard the top entry (ignored when empty)
//   i_clear            : synchronous empty
//   o_top              : current top entry (meaningless when empty)
//   o_empty, o_full    : occupancy flags
module bf_loop_stack #(
    parameter int LOOP_DEPTH = 16,
    parameter int CADDR_W    = 16
) (
    input  logic               clk,
    input  logic               reset_trigger,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_clear,
    input  logic [CADDR_W-1:0] i_push_data,
    output logic [CADDR_W-1:0] o_top,
    output logic               o_empty,
    output logic               o_full
);

    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    logic [CADDR_W-1:0] r_mem [LOOP_DEPTH];
    logic [SP_W-1:0]    r_sp;
    logic [SP_W-1:0]    w_sp_dec;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_top_idx;

    assign w_sp_dec  = r_sp - 1'b1;
    assign w_wr_idx  = IDX_W'(r_sp);
    assign w_top_idx = IDX_W'(w_sp_dec);

    assign o_empty = (r_sp == '0);
    assign o_full  = (r_sp == SP_W'(LOOP_DEPTH));
    assign o_top   = r_mem[w_top_idx];

    // NOTE: the entry array has no reset; r_sp alone decides which entries are live,
    // so clearing the stack never needs to touch the storage.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset_trigger) begin
        if (reset_trigger) begin
            r_sp <= '0;
        end else if (i_clear) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= w_sp_dec;
        end
    end

endmodule

// File: rtl/bf_exec_core.sv
// Brainfuck execution core: runs a 3-bit command stream from a synchronous-read
// program ROM against a synchronous-read cell RAM, with ready/valid byte I/O.
// Ports:
//   clk, reset_trigger        : clock, asynchronous active-high reset
//   start                     : 1-cycle pulse, runs from command 0 / cell 0 (ignored while busy)
//   prog_addr/prog_cmd/prog_end : program ROM (data one cycle after address)
//   cell_addr/cell_rdata      : cell RAM read (data one cycle after address)
//   cell_wdata/cell_we        : cell RAM write strobe
//   out_data/out_valid/out_ready : output byte handshake ('.')
//   in_data/in_valid/in_ready : input byte handshake (',')
//   busy/done/error/err_code  : status
module bf_exec_core
    import bf_pkg::*;
#(
    parameter int CELL_W     = 8,
    parameter int CADDR_W    = 16,
    parameter int DADDR_W    = 16,
    parameter int LOOP_DEPTH = 16,
    parameter int SKIP_W     = 8
) (
    input  logic               clk,
    input  logic               reset_trigger,
    input  logic               start,
    output logic [CADDR_W-1:0] prog_addr,
    input  logic [2:0]         prog_cmd,
    input  logic               prog_end,
    output logic [DADDR_W-1:0] cell_addr,
    input  logic [CELL_W-1:0]  cell_rdata,
    output logic [CELL_W-1:0]  cell_wdata,
    output logic               cell_we,
    output logic [CELL_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [CELL_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    bf_exec_state_t     r_state, w_state_next;
    logic [CADDR_W-1:0] r_pc, w_pc_next;
    logic [DADDR_W-1:0] r_ptr, w_ptr_next;
    logic [SKIP_W-1:0]  r_skip, w_skip_next;
    logic [CELL_W-1:0]  r_out_data, w_out_data_next;
    bf_err_t            r_err, w_err_next;

    bf_cmd_t            w_cmd;
    logic [CADDR_W-1:0] w_pc_inc;
    logic               w_cell_zero;
    logic               w_cell_we;
    logic [CELL_W-1:0]  w_cell_wdata;
    logic               w_push, w_pop, w_clear;
    logic [CADDR_W-1:0] w_top;
    logic               w_empty, w_full;

    assign w_cmd       = bf_cmd_t'(prog_cmd);
    assign w_pc_inc    = r_pc + 1'b1;
    assign w_cell_zero = (cell_rdata == '0);

    bf_loop_stack #(
        .LOOP_DEPTH (LOOP_DEPTH),
        .CADDR_W    (CADDR_W)
    ) u_loop_stack (
        .clk           (clk),
        .reset_trigger (reset_trigger),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_clear       (w_clear),
        .i_push_data   (r_pc),
        .o_top         (w_top),
        .o_empty       (w_empty),
        .o_full        (w_full)
    );

    always_ff @(posedge clk or posedge reset_trigger) begin
        if (reset_trigger) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ptr      <= '0;
            r_skip     <= '0;
            r_out_data <= '0;
            r_err      <= ERR_NONE;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ptr      <= w_ptr_next;
            r_skip     <= w_skip_next;
            r_out_data <= w_out_data_next;
            r_err      <= w_err_next;
        end
    end

    // NOTE: every signal written here is given a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ptr_next      = r_ptr;
        w_skip_next     = r_skip;
        w_out_data_next = r_out_data;
        w_err_next      = r_err;
        w_cell_we       = 1'b0;
        w_cell_wdata    = '0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_clear         = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                    w_pc_next    = '0;
                    w_ptr_next   = '0;
                    w_skip_next  = '0;
                    w_err_next   = ERR_NONE;
                    w_clear      = 1'b1;
                end
            end

            // Addresses are already on prog_addr/cell_addr; the memories register them here.
            ST_FETCH: w_state_next = ST_EXEC;

            ST_EXEC: begin
                if (prog_end) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_FETCH;
                    case (w_cmd)
                        CMD_INC: begin
                            w_cell_we    = 1'b1;
                            w_cell_wdata = cell_rdata + 1'b1;
                            w_pc_next    = w_pc_inc;
                        end
                        CMD_DEC: begin
                            w_cell_we    = 1'b1;
                            w_cell_wdata = cell_rdata - 1'b1;
                            w_pc_next    = w_pc_inc;
                        end
                        CMD_PTR_INC: begin
                            w_ptr_next = r_ptr + 1'b1;
                            w_pc_next  = w_pc_inc;
                        end
                        CMD_PTR_DEC: begin
                            w_ptr_next = r_ptr - 1'b1;
                            w_pc_next  = w_pc_inc;
                        end
                        CMD_LOOP_OPEN: begin
                            if (w_cell_zero) begin
                                w_skip_next  = '0;
                                w_pc_next    = w_pc_inc;
                                w_state_next = ST_SKIP_FETCH;
                            end else if (w_full) begin
                                w_err_next   = ERR_OVF;
                                w_state_next = ST_ERROR;
                            end else begin
                                w_push    = 1'b1;
                                w_pc_next = w_pc_inc;
                            end
                        end
                        CMD_LOOP_CLOSE: begin
                            if (w_empty) begin
                                w_err_next   = ERR_UNMATCHED_CLOSE;
                                w_state_next = ST_ERROR;
                            end else if (!w_cell_zero) begin
                                // Jump to the command after the matching '[', which stays stacked.
                                w_pc_next = w_top + 1'b1;
                            end else begin
                                w_pop     = 1'b1;
                                w_pc_next = w_pc_inc;
                            end
                        end
                        CMD_OUT: begin
                            w_out_data_next = cell_rdata;
                            w_state_next    = ST_OUT_WAIT;
                        end
                        CMD_IN: w_state_next = ST_IN_WAIT;
                        default: w_state_next = ST_FETCH;
                    endcase
                end
            end

            ST_OUT_WAIT: begin
                if (out_ready) begin
                    w_pc_next    = w_pc_inc;
                    w_state_next = ST_FETCH;
                end
            end

            ST_IN_WAIT: begin
                if (in_valid) begin
                    w_cell_we    = 1'b1;
                    w_cell_wdata = in_data;
                    w_pc_next    = w_pc_inc;
                    w_state_next = ST_FETCH;
                end
            end

            ST_SKIP_FETCH: w_state_next = ST_SKIP;

            // r_skip counts nested '[' seen inside the body being skipped.
            ST_SKIP: begin
                if (prog_end) begin
                    w_err_next   = ERR_UNMATCHED_OPEN;
                    w_state_next = ST_ERROR;
                end else if (w_cmd == CMD_LOOP_OPEN) begin
                    if (r_skip == '1) begin
                        w_err_next   = ERR_UNMATCHED_OPEN;
                        w_state_next = ST_ERROR;
                    end else begin
                        w_skip_next  = r_skip + 1'b1;
                        w_pc_next    = w_pc_inc;
                        w_state_next = ST_SKIP_FETCH;
                    end
                end else if (w_cmd == CMD_LOOP_CLOSE && r_skip == '0) begin
                    w_pc_next    = w_pc_inc;
                    w_state_next = ST_FETCH;
                end else begin
                    if (w_cmd == CMD_LOOP_CLOSE) begin
                        w_skip_next = r_skip - 1'b1;
                    end
                    w_pc_next    = w_pc_inc;
                    w_state_next = ST_SKIP_FETCH;
                end
            end

            default: w_state_next = ST_IDLE;
        endcase
    end

    assign prog_addr  = r_pc;
    assign cell_addr  = r_ptr;
    assign cell_we    = w_cell_we;
    assign cell_wdata = w_cell_wdata;
    assign out_data   = r_out_data;
    assign out_valid  = (r_state == ST_OUT_WAIT);
    assign in_ready   = (r_state == ST_IN_WAIT);
    assign busy       = state_is_active(r_state);
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign err_code   = r_err;

endmodule

// File: tb/tb_bf_exec_core.sv
// Self-checking bench for bf_exec_core: directed programs plus random programs,
// each compared against a Brainfuck interpreter kept in the bench.
module tb_bf_exec_core;

    localparam int CELL_W     = 8;
    localparam int CADDR_W    = 16;
    localparam int DADDR_W    = 16;
    localparam int LOOP_DEPTH = 2;
    localparam int SKIP_W     = 8;
    localparam int PROG_MAX   = 300;
    localparam int RAM_SIZE   = 1 << DADDR_W;
    localparam int SKIP_MAX   = (1 << SKIP_W) - 1;
    localparam int MODEL_STEPS = 600;
    localparam int RUN_BUDGET  = 6000;

    logic               clk;
    logic               reset_trigger;
    logic               start;
    logic [CADDR_W-1:0] prog_addr;
    logic [2:0]         prog_cmd;
    logic               prog_end;
    logic [DADDR_W-1:0] cell_addr;
    logic [CELL_W-1:0]  cell_rdata;
    logic [CELL_W-1:0]  cell_wdata;
    logic               cell_we;
    logic [CELL_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic [CELL_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               busy;
    logic               done;
    logic               error;
    logic [1:0]         err_code;

    bf_exec_core #(
        .CELL_W(CELL_W), .CADDR_W(CADDR_W), .DADDR_W(DADDR_W),
        .LOOP_DEPTH(LOOP_DEPTH), .SKIP_W(SKIP_W)
    ) dut (
        .clk(clk), .reset_trigger(reset_trigger), .start(start),
        .prog_addr(prog_addr), .prog_cmd(prog_cmd), .prog_end(prog_end),
        .cell_addr(cell_addr), .cell_rdata(cell_rdata), .cell_wdata(cell_wdata),
        .cell_we(cell_we), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .error(error),
        .err_code(err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program ROM and cell RAM, both with one cycle of read latency.
    logic [2:0]        prog_mem [PROG_MAX];
    int                prog_len;
    logic [CELL_W-1:0] ram [RAM_SIZE];
    logic              ram_clear;

    always @(posedge clk) begin
        prog_end <= (int'(prog_addr) >= prog_len);
        prog_cmd <= (int'(prog_addr) < prog_len) ? prog_mem[prog_addr] : 3'd0;
    end

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < RAM_SIZE; i++) ram[i] <= '0;
        end else if (cell_we) begin
            ram[cell_addr] <= cell_wdata;
        end
        cell_rdata <= ram[cell_addr];
    end

    int n_total;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference interpreter ----------------
    logic [CELL_W-1:0] mcell [RAM_SIZE];
    logic [CELL_W-1:0] in_bytes [$];
    logic [CELL_W-1:0] m_out [$];
    bit                m_done;
    bit                m_err;
    int                m_code;
    int                m_ptr;
    int                m_in_used;

    function automatic logic [2:0] enc(input byte c);
        case (c)
            "+": return 3'd0;
            "-": return 3'd1;
            "[": return 3'd2;
            "]": return 3'd3;
            ">": return 3'd4;
            "<": return 3'd5;
            ".": return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    task automatic load_prog(input string s);
        prog_len = s.len();
        for (int i = 0; i < s.len(); i++) prog_mem[i] = enc(s[i]);
    endtask

    task automatic model_run(output bit ok);
        int pc, ptr, steps, depth, in_idx;
        int stk [$];
        bit stop;
        for (int i = 0; i < RAM_SIZE; i++) mcell[i] = '0;
        m_out.delete();
        m_done = 0; m_err = 0; m_code = 0;
        ok = 1; pc = 0; ptr = 0; steps = 0; in_idx = 0; stop = 0;
        while (!stop) begin
            steps++;
            if (steps > MODEL_STEPS) begin ok = 0; stop = 1; end
            else if (pc >= prog_len) begin m_done = 1; stop = 1; end
            else begin
                case (prog_mem[pc])
                    3'd0: begin mcell[ptr] = mcell[ptr] + 8'd1; pc++; end
                    3'd1: begin mcell[ptr] = mcell[ptr] - 8'd1; pc++; end
                    3'd4: begin ptr = (ptr + 1) % RAM_SIZE; pc++; end
                    3'd5: begin ptr = (ptr + RAM_SIZE - 1) % RAM_SIZE; pc++; end
                    3'd6: begin m_out.push_back(mcell[ptr]); pc++; end
                    3'd7: begin
                        if (in_idx >= in_bytes.size()) begin ok = 0; stop = 1; end
                        else begin mcell[ptr] = in_bytes[in_idx]; in_idx++; pc++; end
                    end
                    3'd2: begin
                        if (mcell[ptr] != 0) begin
                            if (stk.size() == LOOP_DEPTH) begin m_err = 1; m_code = 1; stop = 1; end
                            else begin stk.push_back(pc); pc++; end
                        end else begin
                            // scan forward for the matching ']'
                            bit found;
                            found = 0; depth = 0; pc++;
                            while (!found && !stop) begin
                                steps++;
                                if (pc >= prog_len) begin m_err = 1; m_code = 3; stop = 1; end
                                else if (prog_mem[pc] == 3'd2) begin
                                    if (depth == SKIP_MAX) begin m_err = 1; m_code = 3; stop = 1; end
                                    else begin depth++; pc++; end
                                end else if (prog_mem[pc] == 3'd3) begin
                                    if (depth == 0) found = 1;
                                    else depth--;
                                    pc++;
                                end else pc++;
                            end
                        end
                    end
                    default: begin
                        if (stk.size() == 0) begin m_err = 1; m_code = 2; stop = 1; end
                        else if (mcell[ptr] != 0) pc = stk[$] + 1;
                        else begin void'(stk.pop_back()); pc++; end
                    end
                endcase
            end
        end
        m_ptr = ptr;
        m_in_used = in_idx;
    endtask

    // ---------------- DUT driver ----------------
    logic [CELL_W-1:0] d_out [$];

    task automatic clear_ram();
        ram_clear = 1'b1;
        @(negedge clk);
        ram_clear = 1'b0;
    endtask

    task automatic run_dut(input string tag, input int in_delay, input int out_stall, input bit poke);
        int cyc, inq_idx, rdy_wait, stall_cnt, n_ov, n_ir, n_ram_bad;
        bit prev_stall;
        logic [CELL_W-1:0] prev_data;
        d_out.delete();
        inq_idx = 0; rdy_wait = 0; stall_cnt = 0; n_ov = 0; n_ir = 0;
        prev_stall = 0; prev_data = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < RUN_BUDGET) begin
            start = (poke && cyc == 3);
            if (prev_stall) begin
                check({tag, "_valid_hold"}, out_valid, 1);
                check({tag, "_data_hold"}, out_data, prev_data);
            end
            if (out_valid) begin
                n_ov++;
                out_ready = (stall_cnt >= out_stall);
                if (out_ready) begin
                    d_out.push_back(out_data);
                    stall_cnt = 0; prev_stall = 0;
                end else begin
                    stall_cnt++; prev_stall = 1; prev_data = out_data;
                end
            end else begin
                out_ready = 1'b0;
                prev_stall = 0;
            end
            if (in_ready) begin
                n_ir++; rdy_wait++;
                if (rdy_wait >= in_delay && inq_idx < in_bytes.size()) begin
                    in_valid = 1'b1; in_data = in_bytes[inq_idx];
                    inq_idx++; rdy_wait = 0;
                end else begin
                    in_valid = 1'b0; in_data = CELL_W'($urandom);
                end
            end else begin
                in_valid = ($urandom_range(0, 3) == 0);
                in_data  = CELL_W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check({tag, "_finished"}, busy, 0);
        if (busy) begin
            reset_trigger = 1'b1;
            @(negedge clk);
            reset_trigger = 1'b0;
        end
        check({tag, "_done"}, done, m_done);
        check({tag, "_error"}, error, m_err);
        check({tag, "_err_code"}, err_code, m_code);
        check({tag, "_ptr"}, cell_addr, m_ptr);
        check({tag, "_n_out"}, d_out.size(), m_out.size());
        for (int i = 0; i < d_out.size() && i < m_out.size(); i++)
            check({tag, "_out_byte"}, d_out[i], m_out[i]);
        check({tag, "_n_in"}, inq_idx, m_in_used);
        check({tag, "_out_valid_cycles"}, n_ov, m_out.size() * (out_stall + 1));
        check({tag, "_in_ready_cycles"}, n_ir, m_in_used * in_delay);
        n_ram_bad = 0;
        for (int i = 0; i < RAM_SIZE; i++) if (ram[i] !== mcell[i]) n_ram_bad++;
        check({tag, "_cells"}, n_ram_bad, 0);
    endtask

    task automatic run_test(input string tag, input string prog, input int in_delay,
                            input int out_stall, input bit poke);
        bit ok;
        load_prog(prog);
        clear_ram();
        model_run(ok);
        check({tag, "_model_terminates"}, ok, 1);
        run_dut(tag, in_delay, out_stall, poke);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_prog_addr"}, prog_addr, 0);
        check({tag, "_cell_addr"}, cell_addr, 0);
        check({tag, "_cell_we"}, cell_we, 0);
        check({tag, "_cell_wdata"}, cell_wdata, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        string chars;
        string prog;
        string sat;
        bit ok;
        int cyc;
        n_total = 0; n_bad = 0;
        reset_trigger = 1'b1; start = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_data = '0; ram_clear = 1'b0;
        load_prog("");
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_trigger = 1'b0;
        clear_ram();

        run_test("inc3", "+++.", 1, 0, 0);
        check("inc3_value", d_out.size() > 0 ? d_out[0] : 8'hxx, 8'd3);
        run_test("dec_wrap", "-.", 1, 0, 0);
        check("dec_wrap_value", d_out.size() > 0 ? d_out[0] : 8'hxx, 8'd255);
        run_test("ptr_wrap", "<", 1, 0, 0);
        check("ptr_wrap_addr", cell_addr, 16'hFFFF);
        run_test("mul", "++[>+++<-]>.", 1, 1, 0);
        check("mul_value", d_out.size() > 0 ? d_out[0] : 8'hxx, 8'd6);
        run_test("skip", "[+++].", 1, 0, 0);
        check("skip_value", d_out.size() > 0 ? d_out[0] : 8'hxx, 8'd0);

        in_bytes.delete();
        in_bytes.push_back(8'h41);
        run_test("io", ",+.", 5, 3, 0);
        check("io_value", d_out.size() > 0 ? d_out[0] : 8'hxx, 8'h42);

        run_test("ovf", "+[[[", 1, 0, 0);
        check("ovf_code", err_code, 2'b01);
        run_test("close", "]", 1, 0, 0);
        check("close_code", err_code, 2'b10);
        run_test("open", "[", 1, 0, 0);
        check("open_code", err_code, 2'b11);

        // 255 nested '[' saturate the skip counter; one more must abort even
        // though a closing ']' follows.
        sat = "[";
        for (int i = 0; i < 256; i++) sat = {sat, "["};
        sat = {sat, "]."};
        run_test("skip_sat", sat, 1, 0, 0);
        check("skip_sat_code", err_code, 2'b11);

        // Reset in the middle of an output handshake.
        load_prog("+++.");
        clear_ram();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reached_out_wait", out_valid, 1);
        #2 reset_trigger = 1'b1;
        #1 check_outputs_zero("rst_mid");
        @(negedge clk);
        reset_trigger = 1'b0;
        run_test("rerun", "+++.", 1, 0, 0);
        check("rerun_value", d_out.size() > 0 ? d_out[0] : 8'hxx, 8'd3);

        // Random programs; some restart pulses land while busy and must be ignored.
        chars = "+++--><>[[]].,";
        for (int t = 0; t < 24; t++) begin
            in_bytes.delete();
            for (int i = 0; i < 16; i++) in_bytes.push_back(CELL_W'($urandom));
            ok = 0;
            for (int a = 0; a < 60 && !ok; a++) begin
                int len;
                len = $urandom_range(3, 16);
                prog = "";
                for (int i = 0; i < len; i++) begin
                    string ch;
                    ch = " ";
                    ch[0] = chars[$urandom_range(0, chars.len() - 1)];
                    prog = {prog, ch};
                end
                load_prog(prog);
                model_run(ok);
            end
            if (!ok) prog = "+.";
            run_test("rand", prog, $urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
